// File: rtl/program_loader_pkg.sv
// Shared types and sizing helpers for the program loader.
// Optional macro PROG_LOADER_CHECKSUM_EN adds the CSUM state to the enum.
// Pure declarations; no logic.
package program_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } loader_state_e;

  // Number of whole instruction words that fit in the byte-addressed memory.
  function automatic int unsigned max_words(input int unsigned addr_w, input int unsigned inst_w);
    return (32'd1 << addr_w) / (inst_w / 8);
  endfunction

  // Word capacity of the default 12-bit / 16-bit configuration.
  localparam int unsigned MAX_WORDS = max_words(12, 16);

endpackage

// File: rtl/program_loader.sv
// Streams a length-prefixed little-endian program into instruction memory while holding the core in reset.
// Latency: one WRITE cycle per word after its last byte; status/strobes are registered (one cycle after the deciding edge).
// Backpressure: rx_ready drops in WRITE and whenever no load is running. Macro PROG_LOADER_CHECKSUM_EN adds a trailing 8-bit zero-sum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int INST_W   = 16,
  parameter int I_ADDR_W = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [I_ADDR_W-1:0] imem_waddr,
  output logic [INST_W-1:0]   imem_wdata,
  output logic                imem_we,
  output logic                core_reset_n,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int unsigned BYTES      = INST_W / 8;
  localparam int unsigned BC_W       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned WORD_LIMIT = max_words(I_ADDR_W, INST_W);

  // Single-byte words go straight to the final-byte state.
  localparam loader_state_e DATA_FIRST = (BYTES > 1) ? DATA_LO : DATA_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam loader_state_e END_STATE = CSUM;
`else
  localparam loader_state_e END_STATE = DONE;
`endif

  loader_state_e       state_q, state_d;
  logic [15:0]         index_q, index_d;
  logic [15:0]         len_q, len_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [INST_W-1:0]   word_q, word_d;
  logic [15:0]         n_words;
  logic                xfer;
  logic [I_ADDR_W-1:0] addr_d;
  logic                rdy_d, busy_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic                rx_ready_q, imem_we_q, busy_q, done_q, error_q, core_en_q;
  logic [I_ADDR_W-1:0] imem_waddr_q;
  logic [INST_W-1:0]   imem_wdata_q;

  assign xfer    = rx_valid && rx_ready_q;
  assign n_words = {rx_data, len_q[7:0]};
  assign addr_d  = I_ADDR_W'(32'(index_q) * BYTES);

  // Next-state, byte assembly, word index and checksum accumulation.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    if (xfer) sum_d = sum_q + rx_data;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = LEN_LO;
          index_d    = '0;
          byte_cnt_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = rx_data;
          byte_cnt_d  = '0;
          if (32'(n_words) > WORD_LIMIT) state_d = ERROR;
          else if (n_words == 16'd0)     state_d = END_STATE;
          else                           state_d = DATA_FIRST;
        end
      end
      DATA_LO, DATA_HI: begin
        if (xfer) begin
          for (int b = 0; b < int'(BYTES); b++) begin
            if (BC_W'(b) == byte_cnt_q) word_d[8*b +: 8] = rx_data;
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (state_q == DATA_HI) begin
            state_d    = WRITE;
            byte_cnt_d = '0;
          end else if (32'(byte_cnt_q) == BYTES - 2) begin
            state_d = DATA_HI;
          end
        end
      end
      WRITE: begin
        index_d = index_q + 16'd1;
        state_d = (index_q == len_q - 16'd1) ? END_STATE : DATA_FIRST;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) state_d = (sum_d == 8'd0) ? DONE : ERROR;
      end
`endif
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
            (state_d == DATA_LO) || (state_d == DATA_HI);
`ifdef PROG_LOADER_CHECKSUM_EN
    if (state_d == CSUM) rdy_d = 1'b1;
`endif
    busy_d = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERROR));
  end

  // State registers plus outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      index_q      <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_en_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
      rx_ready_q   <= rdy_d;
      imem_we_q    <= (state_d == WRITE);
      if (state_d == WRITE) begin
        imem_waddr_q <= addr_d;
        imem_wdata_q <= word_d;
      end
      busy_q       <= busy_d;
      done_q       <= (state_d == DONE);
      error_q      <= (state_d == ERROR);
      core_en_q    <= (state_d == IDLE) || (state_d == DONE);
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_waddr   = imem_waddr_q;
  assign imem_wdata   = imem_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign core_reset_n = reset_n && core_en_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued when a stream is driven
// and popped by a monitor on every imem_we cycle; scenario tasks check status inline.
module tb_program_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, imem_we, core_reset_n, busy, done, error;
  logic [11:0] imem_waddr;
  logic [15:0] imem_wdata;

  int errors = 0;
  int checks = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  program_loader #(.INST_W(16), .I_ADDR_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .imem_we(imem_we), .core_reset_n(core_reset_n),
    .busy(busy), .done(done), .error(error)
  );

  // Write monitor: every strobe must match the oldest expected write, with rx_ready low.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (reset_n && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, none expected", imem_waddr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_waddr !== e.a || imem_wdata !== e.d) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h, want addr=%h data=%h", imem_waddr, imem_wdata, e.a, e.d);
        end
      end
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write: got rx_ready=%b want 0", rx_ready);
      end
    end
  end

  function automatic bq_t add_csum(input bq_t s);
    bq_t r = s;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum = 8'd0;
    foreach (s[i]) sum = sum + s[i];
    r.push_back(8'd0 - sum);
`endif
    return r;
  endfunction

  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n = 0;
    rx_data = b;
    while (rx_ready !== 1'b1 && n < 100) begin
      rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: rx_ready stuck at %b, want 1", rx_ready);
    end
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_stream(input bq_t s, input bit rnd);
    foreach (s[i]) send_byte(s[i], rnd);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL end_timeout: done=%b error=%b, want one set", done, error);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({rx_ready, imem_we, busy, done, error, core_reset_n} !== 6'b0 ||
        imem_waddr !== 12'h000 || imem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL %s: got rdy=%b we=%b busy=%b done=%b err=%b crst=%b addr=%h data=%h, want all 0",
               tag, rx_ready, imem_we, busy, done, error, core_reset_n, imem_waddr, imem_wdata);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    reset_n = 1'b1;
    #1;
    checks++;
    if (core_reset_n !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got crst=%b busy=%b rdy=%b, want 1 0 0", core_reset_n, busy, rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignore: got rdy=%b busy=%b, want 0 0", rx_ready, busy);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_basic(input bit rnd, input string tag);
    bq_t s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    exp_q.push_back('{a: 12'h000, d: 16'h1234});
    exp_q.push_back('{a: 12'h002, d: 16'h5678});
    start_load();
    checks++;
    if (core_reset_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_loading: got crst=%b busy=%b done=%b, want 0 1 0", tag, core_reset_n, busy, done);
    end
    send_stream(add_csum(s), rnd);
    wait_end();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || core_reset_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got done=%b err=%b crst=%b busy=%b, want 1 0 1 0", tag, done, error, core_reset_n, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: got %0d writes missing, want 0", tag, exp_q.size());
    end
  endtask

  task automatic test_zero();
    bq_t s = '{8'h00, 8'h00};
    start_load();
    send_stream(add_csum(s), 1'b0);
    wait_end();
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || core_reset_n !== 1'b1) begin
      errors++;
      $display("FAIL zero_len: got done=%b err=%b crst=%b, want 1 0 1", done, error, core_reset_n);
    end
  endtask

  task automatic test_overflow();
    start_load();
    send_byte(8'h01, 1'b0);
    send_byte(8'h08, 1'b0);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || core_reset_n !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow: got err=%b done=%b crst=%b busy=%b, want 1 0 0 0", error, done, core_reset_n, busy);
    end
    rx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b0 || core_reset_n !== 1'b0 || error !== 1'b1) begin
        errors++;
        $display("FAIL error_hold: got rdy=%b crst=%b err=%b, want 0 0 1", rx_ready, core_reset_n, error);
      end
    end
    rx_valid = 1'b0;
    // Exactly the capacity (2048 words) must be accepted.
    start_load();
    checks++;
    if (error !== 1'b0 || core_reset_n !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: got err=%b crst=%b, want 0 0", error, core_reset_n);
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h08, 1'b0);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL max_len: got err=%b busy=%b rdy=%b, want 0 1 1", error, busy, rx_ready);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_midload_reset();
    bq_t s = '{8'h02, 8'h00, 8'h34, 8'h12};
    int n = 0;
    exp_q.push_back('{a: 12'h000, d: 16'h1234});
    exp_q.push_back('{a: 12'h002, d: 16'h5678});
    start_load();
    send_stream(s, 1'b0);
    while (exp_q.size() != 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 1) begin
      errors++;
      $display("FAIL first_write: got %0d pending, want 1", exp_q.size());
    end
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    check_reset_values("midload_reset");
    repeat (2) @(negedge clk);
    check_reset_values("midload_hold");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    test_basic(1'b0, "rerun");
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bq_t good = '{8'h01, 8'h00, 8'h34, 8'h12, 8'hB9};
    bq_t bad  = '{8'h01, 8'h00, 8'h34, 8'h12, 8'hB8};
    exp_q.push_back('{a: 12'h000, d: 16'h1234});
    start_load();
    send_stream(good, 1'b0);
    wait_end();
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL csum_good: got done=%b err=%b, want 1 0", done, error);
    end
    exp_q.push_back('{a: 12'h000, d: 16'h1234});
    start_load();
    send_stream(bad, 1'b0);
    wait_end();
    checks++;
    if (done !== 1'b0 || error !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL csum_bad: got done=%b err=%b pending=%0d, want 0 1 0", done, error, exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(1'b0, "basic");
    test_zero();
    test_overflow();
    test_basic(1'b1, "random_valid");
    test_midload_reset();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
